if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 11 +
 rtl/if_stage_pc_gen.sv | 53 +++++
 rtl/if_stage.sv | 89 ++++++++
 tb/tb_if_stage.sv | 134 +++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction fetch stage: datapath width, reset PC,
// bubble instruction and the JAL opcode used by the optional predictor.
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [6:0]      OPCODE_JAL        = 7'b1101111;

endpackage

// File: rtl/if_stage_pc_gen.sv
// Next-PC generation: priority mux over reset, redirect, stall, JAL prediction
// and sequential PC+4. Prediction is built only when IF_JAL_PREDICT_EN is defined.
module pc_gen
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken
);

  logic [XLEN-1:0] jal_target;

`ifdef IF_JAL_PREDICT_EN
  logic signed [20:0]     jal_imm;
  logic signed [XLEN-1:0] jal_imm_ext;
  logic                   unused_instr;

  assign jal_imm      = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign jal_imm_ext  = XLEN'(jal_imm);
  assign jal_target   = pc + $unsigned(jal_imm_ext);
  assign pred_taken   = (instr[6:0] == OPCODE_JAL);
  assign unused_instr = ^instr[11:7];
`else
  logic unused_instr;

  assign jal_target   = '0;
  assign pred_taken   = 1'b0;
  assign unused_instr = ^instr;
`endif

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    next_pc = pc_plus4;
    if (rst)
      next_pc = RESET_PC;
    else if (redirect_valid)
      next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    else if (stall)
      next_pc = pc;
    else if (pred_taken)
      next_pc = jal_target;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Optional static JAL prediction is enabled with the IF_JAL_PREDICT_EN macro.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_valid,
  output logic            id_flush,
  output logic            if_id_pred_taken,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pred_taken;

  logic [XLEN-1:0] instr_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] pc_plus4_p1;
  logic            vld_p1;
  logic            pred_p1;
  logic [XLEN-1:0] count;

  pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc_p0),
    .instr         (imem_rdata),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .pred_taken    (pred_taken)
  );

  // Stage 0: PC register; next_pc already folds in reset, redirect and stall.
  always_ff @(posedge clk) begin
    pc_p0 <= next_pc;
  end

  // Stage 1: IF/ID register and accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= '0;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
      pred_p1     <= 1'b0;
      count       <= '0;
    end else if (redirect_valid) begin
      // Squash the slot but keep its PC fields for debug visibility.
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      pred_p1  <= 1'b0;
    end else if (!stall) begin
      instr_p1    <= imem_rdata;
      pc_p1       <= pc_p0;
      pc_plus4_p1 <= pc_plus4;
      vld_p1      <= 1'b1;
      pred_p1     <= pred_taken;
      count       <= count + XLEN'(1);
    end
  end

  assign imem_addr        = pc_p0;
  assign if_id_instr      = instr_p1;
  assign if_id_pc         = pc_p1;
  assign if_id_pc_plus4   = pc_plus4_p1;
  assign if_id_valid      = vld_p1;
  assign id_flush         = ~vld_p1;
  assign if_id_pred_taken = pred_p1;
  assign fetch_count      = count;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural model predicts every cycle's
// visible state, and an independent monitor compares it on the falling edge.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, id_flush, if_id_pred_taken;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .id_flush(id_flush), .if_id_pred_taken(if_id_pred_taken),
    .fetch_count(fetch_count)
  );

  logic [31:0] jal_addr = 32'h0000_0040;

  // Instruction memory: hashed words with a non-JAL opcode, one JAL (+16) planted.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == jal_addr) return 32'h0100_006F;
    w = (a * 32'h9E37_79B1) ^ 32'h1234_5600;
    w[6:0] = 7'h33;
    return w;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] addr, instr, ipc, ipc4;
    logic        vld, pred;
    logic [31:0] cnt;
  } snap_t;

  snap_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic        m_vld, m_pred;
  bit          m_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_addr",   imem_addr,        e.addr);
      chk("instr",       if_id_instr,      e.instr);
      chk("if_id_pc",    if_id_pc,         e.ipc);
      chk("pc_plus4",    if_id_pc_plus4,   e.ipc4);
      chk("valid",       32'(if_id_valid), 32'(e.vld));
      chk("id_flush",    32'(id_flush),    32'(!e.vld));
      chk("pred_taken",  32'(if_id_pred_taken), 32'(e.pred));
      chk("fetch_count", fetch_count,      e.cnt);
    end
  end

  // Apply one cycle of inputs, record what must be visible now, advance the model.
  task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rp);
    logic [31:0] w, npc, off;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    if (m_ok) exp_q.push_back('{m_pc, m_instr, m_ipc, m_ipc4, m_vld, m_pred, m_cnt});
    w = mem_word(m_pc);
    if (r) begin
      m_pc = RST_PC; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
      m_vld = 0; m_pred = 0; m_cnt = 0; m_ok = 1;
    end else if (rv) begin
      m_pc = rp & ~32'd3; m_instr = NOP; m_vld = 0; m_pred = 0;
    end else if (!s) begin
      npc = m_pc + 4;
      m_pred = 0;
`ifdef IF_JAL_PREDICT_EN
      if (w[6:0] == 7'h6F) begin
        off = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        npc = m_pc + off;
        m_pred = 1;
      end
`else
      off = 0;
`endif
      m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_vld = 1;
      m_cnt = m_cnt + 1; m_pc = npc;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    repeat (3) step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_2003);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFF4);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_003C);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0500);
    step(1, 1, 1, 32'h0000_5000);
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 2) == 0) ? 32'h0000_003C : $urandom;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), rp);
    end
    repeat (2) step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
